// File: rtl/ara_inval_sequencer.sv
// ara_inval_sequencer
//
// Turns write bursts that Ara issues on its AXI AW channel into a stream of
// per-cache-line L1 invalidation requests toward CVA6. Each accepted AW is
// reduced to a (first line, line count) descriptor and queued. The head
// descriptor is then walked one line per cycle over a valid/ready handshake.
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   en_i            coherence enable; when low, AWs are accepted but not tracked
//   aw_valid_i      snooped AW handshake valid
//   aw_ready_o      AW may be accepted (low only when tracking and queue full)
//   aw_addr_i       AW start address
//   aw_len_i        AXI burst length minus one
//   aw_size_i       AXI log2 bytes per beat
//   aw_burst_i      AXI burst type (FIXED, INCR, WRAP; reserved acts as INCR)
//   inval_addr_o    line-aligned invalidation address
//   inval_valid_o   invalidation request valid
//   inval_ready_i   core accepts the invalidation
//   busy_o          queue non-empty or invalidation in flight
//   pending_o       number of queued descriptors, including the one being walked
module ara_inval_sequencer #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned FifoDepth   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         aw_valid_i,
    output logic                         aw_ready_o,
    input  logic [AddrWidth-1:0]         aw_addr_i,
    input  logic [7:0]                   aw_len_i,
    input  logic [2:0]                   aw_size_i,
    input  logic [1:0]                   aw_burst_i,
    output logic [AddrWidth-1:0]         inval_addr_o,
    output logic                         inval_valid_o,
    input  logic                         inval_ready_i,
    output logic                         busy_o,
    output logic [$clog2(FifoDepth):0]   pending_o
);

    localparam int unsigned LineShift   = $clog2(L1LineWidth);
    localparam int unsigned LineWidth   = AddrWidth - LineShift;
    // Largest burst is 256 beats of 128 bytes; an unaligned start adds a line.
    localparam int unsigned NLinesWidth = $clog2(32768 / L1LineWidth + 1);
    localparam int unsigned PtrWidth    = $clog2(FifoDepth);
    localparam int unsigned CountWidth  = PtrWidth + 1;

    typedef struct packed {
        logic [LineWidth-1:0]   line_start;
        logic [NLinesWidth-1:0] nlines;
    } desc_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    desc_t                  fifo_mem [FifoDepth];
    logic [PtrWidth-1:0]    rd_ptr, wr_ptr;
    logic [CountWidth-1:0]  count;

    state_t                 state, state_n;
    logic [LineWidth-1:0]   cur_line, cur_line_n;
    logic [NLinesWidth-1:0] remaining, remaining_n;

    logic [AddrWidth-1:0]   beat_bytes, burst_bytes, first_addr, last_addr;
    logic [LineWidth-1:0]   first_line, last_line;
    desc_t                  new_desc, head_desc, next_desc;
    logic                   full, push, pop, head_avail, next_avail;

    assign full       = (count == CountWidth'(FifoDepth));
    assign aw_ready_o = !en_i || !full;
    assign push       = aw_valid_i && aw_ready_o && en_i;

    assign inval_valid_o = (state == ISSUE);
    assign inval_addr_o  = {cur_line, {LineShift{1'b0}}};
    assign busy_o        = (count != '0) || inval_valid_o;
    assign pending_o     = count;

    // Reduce the incoming AW to its first line and line count. All address
    // arithmetic is modulo 2^AddrWidth, so a burst crossing the top of the
    // address space simply wraps its line numbers around to zero.
    always_comb begin
        beat_bytes  = AddrWidth'(1) << aw_size_i;
        burst_bytes = (AddrWidth'(aw_len_i) + AddrWidth'(1)) << aw_size_i;
        first_addr  = aw_addr_i;
        last_addr   = aw_addr_i + burst_bytes - AddrWidth'(1);
        case (aw_burst_i)
            2'b00: last_addr = aw_addr_i + beat_bytes - AddrWidth'(1);
            2'b10: begin
                first_addr = aw_addr_i & ~(burst_bytes - AddrWidth'(1));
                last_addr  = first_addr + burst_bytes - AddrWidth'(1);
            end
            default: ;
        endcase
        first_line          = LineWidth'(first_addr >> LineShift);
        last_line           = LineWidth'(last_addr >> LineShift);
        new_desc.line_start = first_line;
        new_desc.nlines     = NLinesWidth'(last_line - first_line + LineWidth'(1));
    end

    // A descriptor being pushed this cycle is forwarded straight to the walker
    // when the queue holds nothing ahead of it, giving one-cycle AW-to-request
    // latency without waiting for the FIFO write to land.
    always_comb begin
        head_avail = (count != '0) || push;
        head_desc  = (count != '0) ? fifo_mem[rd_ptr] : new_desc;
        next_avail = (count > CountWidth'(1)) || push;
        next_desc  = (count > CountWidth'(1)) ? fifo_mem[rd_ptr + PtrWidth'(1)] : new_desc;
    end

    // Walker next-state logic. The head entry stays in the FIFO while it is
    // being walked and is popped only on its last line's handshake.
    always_comb begin
        state_n     = state;
        cur_line_n  = cur_line;
        remaining_n = remaining;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (head_avail) begin
                    cur_line_n  = head_desc.line_start;
                    remaining_n = head_desc.nlines;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                if (inval_ready_i) begin
                    if (remaining != NLinesWidth'(1)) begin
                        remaining_n = remaining - NLinesWidth'(1);
                        cur_line_n  = cur_line + LineWidth'(1);
                    end else begin
                        pop = 1'b1;
                        if (next_avail) begin
                            cur_line_n  = next_desc.line_start;
                            remaining_n = next_desc.nlines;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, walker and FIFO bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cur_line  <= '0;
            remaining <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_n;
            cur_line  <= cur_line_n;
            remaining <= remaining_n;
            if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
            count <= count + CountWidth'(push) - CountWidth'(pop);
        end
    end

    // Descriptor storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= new_desc;
    end

endmodule

// File: doc/ara_inval_sequencer.md
Name: ara_inval_sequencer

Overview:
- Converts write bursts issued by Ara on its AXI port into a stream of per-cache-line L1 invalidation requests toward CVA6.
- Sits between Ara's AW channel tap and the core's invalidation handshake.
- Queues accepted AW descriptors and walks each one line by line.
- Backpressures AW when the queue is full, so no write reaches memory untracked.

Parameters:
AddrWidth, 64, address width of AW and invalidation addresses
L1LineWidth, 16, L1 D-cache line size in bytes; power of two, at least 8
FifoDepth, 4, number of queued AW descriptors; power of two, at least 2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
en_i  in  1  coherence enable; when low, AWs pass untracked
aw_valid_i  in  1  AW descriptor valid (snooped AW handshake)
aw_ready_o  out  1  descriptor may be accepted
aw_addr_i  in  AddrWidth  AW start address
aw_len_i  in  8  AXI burst length minus 1
aw_size_i  in  3  AXI log2 bytes per beat
aw_burst_i  in  2  AXI burst type (00 FIXED, 01 INCR, 10 WRAP)
inval_addr_o  out  AddrWidth  line-aligned invalidation address
inval_valid_o  out  1  invalidation request valid
inval_ready_i  in  1  core accepts invalidation
busy_o  out  1  FIFO non-empty or invalidation in flight
pending_o  out  $clog2(FifoDepth)+1  queued descriptor count, including the head

Behaviour:
- Reset (rst_i high at a clock edge): FIFO empty, FSM in IDLE, inval_valid_o=0, inval_addr_o=0, busy_o=0, pending_o=0.
- Reset has priority over every other event and aborts a walk mid-burst; no further requests are issued for that burst.
- aw_ready_o = !en_i | !full. It depends only on registered state, never on inval_ready_i.
- Enqueue occurs on aw_valid_i & aw_ready_o & en_i. With en_i=0, the handshake completes and nothing is queued.
- Descriptor computation at enqueue, with bytes = (len+1) << size:
  - INCR: first = addr; last = addr + bytes - 1.
  - FIXED: first = addr; last = addr + (1 << size) - 1.
  - WRAP: first = addr & ~(bytes-1); last = first + bytes - 1.
  - Reserved burst type 11 is treated as INCR.
- Stored fields: line_start = first >> log2(L1LineWidth); nlines = (last >> log2 L) - line_start + 1. nlines width covers 32768/L1LineWidth + 1.
- Address arithmetic is mod 2^AddrWidth. A burst wrapping past the top of the address space wraps line addresses to 0.
- FSM states:
  - IDLE: if FIFO non-empty, load head, set inval_addr_o = line_start << log2 L, assert inval_valid_o, go to ISSUE.
  - ISSUE: on inval_valid_o & inval_ready_i, decrement the line counter.
    - If lines remain: inval_addr_o += L1LineWidth and valid stays high (one line per cycle throughput).
    - On the last line: pop the FIFO. If the next entry is available, load it in the same cycle and stay in ISSUE, otherwise go to IDLE with valid low.
- Output stability: while inval_valid_o & !inval_ready_i, inval_addr_o and inval_valid_o hold stable. Valid is never retracted without a handshake, including when en_i falls.
- Latency: an AW accepted at cycle N into an empty, idle block gives inval_valid_o high at N+1.
- Simultaneous push and pop when full: aw_ready_o is 0 that cycle; the slot is freed for the next cycle.
- en_i falling mid-operation: entries already queued still drain completely. Only new AWs bypass tracking.
- busy_o = FIFO non-empty | inval_valid_o.
- pending_o updates the cycle after a push or pop.

Test Plan:
- INCR, addr=0x1000, len=3, size=3, L=16: 32 bytes → invalidations 0x1000 then 0x1010, both accepted on consecutive cycles; busy_o falls the cycle after the second handshake.
- Unaligned INCR, addr=0x100C, len=0, size=3: spans 0x100C–0x1013 → two invalidations, 0x1000 and 0x1010.
- WRAP, addr=0x2018, len=3, size=3: 32-byte window 0x2000–0x201F → invalidations 0x2000 and 0x2010. FIXED, addr=0x3000, len=7, size=2 → single invalidation 0x3000.
- Backpressure and full FIFO: inval_ready_i=0 for 20 cycles while 6 single-line AWs arrive (FifoDepth=4):
  - exactly 4 are accepted, aw_ready_o=0 thereafter, pending_o=4;
  - inval_addr_o stays stable while held;
  - after release, the addresses drain in order and aw_ready_o returns 1 the cycle after the first pop.
- en_i=0: 3 AWs with aw_valid_i=1 are all accepted in 3 cycles, with no inval_valid_o and pending_o=0. en_i dropped after 2 queued bursts: both still fully drain.
- Assert rst_i during the 2nd line of a 4-line burst: next cycle inval_valid_o=0, pending_o=0, busy_o=0. A new AW afterwards issues from its own first line only.
